snake_input_pio: RTL

Avalon-MM responder in the FPGA fabric that serves HPS reads of the snake game's player inputs over the lightweight HPS-to-FPGA bridge. It synchronizes and debounces the four active-low pushbuttons, samples the ten slider switches and captures press edges. It exposes data, interrupt-mask and edge-capture registers, and raises an optional level interrupt to the HPS.

---
 rtl/snake_input_pkg.sv | 39 +++
 rtl/snake_input_pio_debouncer.sv | 80 ++++++++
 rtl/snake_input_pio.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/snake_input_pkg.sv
// -----------------------------------------------------------------------------
// snake_input_pkg
//
// Shared constants for the snake game player-input PIO: register word
// offsets, input counts and the DATA register field layout.
//
// Build option: define SNAKE_INPUT_IRQ_EN to implement the IRQMASK register
// and the irq output in snake_input_pio.
// -----------------------------------------------------------------------------
package snake_input_pkg;

  // Input counts
  localparam int NUM_BUTTONS  = 4;
  localparam int NUM_SWITCHES = 10;

  // Avalon word offsets
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE    = 2'd2;

  // DATA register field positions
  localparam int DATA_BTN_LSB = 0;
  localparam int DATA_BTN_MSB = DATA_BTN_LSB + NUM_BUTTONS - 1;
  localparam int DATA_SW_LSB  = DATA_BTN_MSB + 1;
  localparam int DATA_SW_MSB  = DATA_SW_LSB + NUM_SWITCHES - 1;

  // Assemble the 32-bit DATA word from its fields; unused bits read 0.
  function automatic logic [31:0] pack_data(
    input logic [NUM_BUTTONS-1:0]  buttons,
    input logic [NUM_SWITCHES-1:0] switches
  );
    logic [31:0] word;
    word = '0;
    word[DATA_BTN_MSB:DATA_BTN_LSB] = buttons;
    word[DATA_SW_MSB:DATA_SW_LSB]   = switches;
    return word;
  endfunction

endpackage

// File: rtl/snake_input_pio_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// One active-low pushbutton: 2-FF synchronizer, inversion to active-high,
// and a consecutive-stable-cycles debouncer.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous reset, active-high
//   key_n  in   raw asynchronous KEY pin, active-low
//   level  out  debounced button level, 1 = pressed
//   press  out  high during the cycle whose clock edge flips level 0->1,
//               so a register loaded from it changes on the same edge as level
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing samples needed to accept a change
//                    (>= 2)
//   CNT_W            counter width, 2**CNT_W > DEBOUNCE_CYCLES
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_n;
  logic             sync2_n;
  logic             pressed_sync;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             differs;
  logic             at_limit;

  // Synchronizer resets to the released pin level (high), so a reset never
  // looks like a press.
  // NOTE: every clocked process uses non-blocking (<=) assignments so that
  // all flops sample pre-edge values; blocking here would collapse the
  // two-stage synchronizer into one stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_n <= 1'b1;
      sync2_n <= 1'b1;
    end else begin
      sync1_n <= key_n;
      sync2_n <= sync1_n;
    end
  end

  assign pressed_sync = ~sync2_n;
  assign differs      = (pressed_sync != stable);
  assign at_limit     = (cnt == CNT_LAST);

  // Counter tracks how long the synced input has disagreed with the stable
  // state; any agreement restarts the count, so short bounces are absorbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (!differs) begin
      cnt <= '0;
    end else if (at_limit) begin
      stable <= ~stable;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign level = stable;
  // Flip is about to happen and it is a release->press transition.
  assign press = differs && at_limit && !stable;

endmodule

// File: rtl/snake_input_pio.sv
// -----------------------------------------------------------------------------
// snake_input_pio
//
// Avalon-MM responder on the lightweight HPS-to-FPGA bridge exposing the
// snake game's player inputs: four debounced pushbuttons, ten synchronized
// slider switches, sticky press-edge capture and an optional level irq.
//
// Register map (word offsets):
//   0 DATA    RO    [3:0] debounced buttons (1 = pressed), [13:4] switches
//   1 IRQMASK RW    [3:0] interrupt mask (reads 0 without SNAKE_INPUT_IRQ_EN)
//   2 EDGE    R/W1C [3:0] sticky press-edge flags
//   3 reserved, reads 0, writes ignored
//
// Ports:
//   clk_clk                 in   system clock (single domain)
//   reset_reset             in   synchronous reset, active-high
//   pushbuttons_export[3:0] in   raw KEY pins, active-low, asynchronous
//   slider_switches_export  in   raw switch pins [9:0], asynchronous
//   avs_address[1:0]        in   word address
//   avs_read                in   read strobe
//   avs_write               in   write strobe
//   avs_writedata[31:0]     in   write data
//   avs_readdata[31:0]      out  registered read data
//   avs_readdatavalid       out  one-cycle pulse qualifying avs_readdata
//   irq                     out  level interrupt, |(edge & mask)
//
// Build option: define SNAKE_INPUT_IRQ_EN to implement IRQMASK and irq;
// otherwise the mask is absent, irq is tied low and software polls EDGE.
// -----------------------------------------------------------------------------
module snake_input_pio
  import snake_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic [NUM_BUTTONS-1:0]  pushbuttons_export,
  input  logic [NUM_SWITCHES-1:0] slider_switches_export,
  input  logic [1:0]              avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  output logic [31:0]             avs_readdata,
  output logic                    avs_readdatavalid,
  output logic                    irq
);

  logic [NUM_BUTTONS-1:0]  btn_level;
  logic [NUM_BUTTONS-1:0]  btn_press;
  logic [NUM_SWITCHES-1:0] sw_sync1;
  logic [NUM_SWITCHES-1:0] sw_sync2;
  logic [NUM_BUTTONS-1:0]  edge_q;
  logic [NUM_BUTTONS-1:0]  edge_d;
  logic [NUM_BUTTONS-1:0]  w1c;
  logic [NUM_BUTTONS-1:0]  mask_q;
  logic [31:0]             rd_mux;
  logic                    unused_wdata;

  // Only the low nibble of write data is meaningful in any register.
  assign unused_wdata = ^avs_writedata[31:NUM_BUTTONS];

  // ---------------------------------------------------------------------------
  // Button debouncers
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_btn (
      .clk   (clk_clk),
      .rst   (reset_reset),
      .key_n (pushbuttons_export[i]),
      .level (btn_level[i]),
      .press (btn_press[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Switch synchronizer (no debounce; switches are read as plain levels)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sw_sync1 <= '0;
      sw_sync2 <= '0;
    end else begin
      sw_sync1 <= slider_switches_export;
      sw_sync2 <= sw_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge capture with write-1-to-clear. A new press wins over a clear in the
  // same cycle so a press is never lost.
  // ---------------------------------------------------------------------------
  // NOTE: combinational processes assign a default to every output first;
  // a path that leaves a variable unassigned infers a latch.
  always_comb begin
    w1c = '0;
    if (avs_write && (avs_address == ADDR_EDGE)) begin
      w1c = avs_writedata[NUM_BUTTONS-1:0];
    end
    edge_d = (edge_q & ~w1c) | btn_press;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      edge_q <= '0;
    end else begin
      edge_q <= edge_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt mask and irq
  // ---------------------------------------------------------------------------
`ifdef SNAKE_INPUT_IRQ_EN
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      mask_q <= '0;
    end else if (avs_write && (avs_address == ADDR_IRQMASK)) begin
      mask_q <= avs_writedata[NUM_BUTTONS-1:0];
    end
  end

  assign irq = |(edge_q & mask_q);
`else
  assign mask_q = '0;
  assign irq    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read path. The mux sees pre-edge register values, so a read issued with
  // a write to the same register returns the value before the write.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA:    rd_mux = pack_data(btn_level, sw_sync2);
      ADDR_IRQMASK: rd_mux[NUM_BUTTONS-1:0] = mask_q;
      ADDR_EDGE:    rd_mux[NUM_BUTTONS-1:0] = edge_q;
      default:      rd_mux = '0;
    endcase
  end

  // Reset clears the valid flag, dropping any read accepted at the same edge.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) begin
        avs_readdata <= rd_mux;
      end
    end
  end

endmodule
